// File: rtl/regfile_sb_if.sv
// Bus between decode/issue/writeback and the register file scoreboard.
// No valid/ready pairs here: reads are combinational, we/rsv_en/flush take effect at the next posedge.
interface regfile_sb_if #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [NRD-1:0]       rbusy;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_a;
  logic                 flush;
  logic [AW:0]          busy_cnt;

  modport master (
    output ra, we, wa, wd, rsv_en, rsv_a, flush,
    input  rd, rbusy, busy_cnt
  );

  modport slave (
    input  ra, we, wa, wd, rsv_en, rsv_a, flush,
    output rd, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with NRD async read ports, one sync write port, optional
// write-to-read bypass and a per-register busy scoreboard with flush.
module regfile_sb #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Index names a real storage register: in range and not the hardwired zero.
  function automatic logic valid_idx(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && (32'(a) != 32'(ZERO_REG));
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == ZERO_REG) ? '0 : WIDTH'(i);
    end else if (bus.we && valid_idx(bus.wa)) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Later assignments win: flush over reserve over writeback clear.
  always_comb begin
    busy_nxt = busy;
    if (bus.we && valid_idx(bus.wa))
      busy_nxt[bus.wa] = 1'b0;
    if (bus.rsv_en && valid_idx(bus.rsv_a))
      busy_nxt[bus.rsv_a] = 1'b1;
    if (bus.flush)
      busy_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      bus.busy_cnt <= '0;
    end else begin
      busy         <= busy_nxt;
      bus.busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = bus.ra[k*AW +: AW];
    assign hit = (BYPASS != 0) && bus.we && (bus.wa == a) && valid_idx(a);
    assign bus.rd[k*WIDTH +: WIDTH] = !valid_idx(a) ? '0 :
                                      hit           ? bus.wd : regs[a];
    assign bus.rbusy[k] = valid_idx(a) && !hit && busy[a];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus
// and are checked against a queue-based model of registers and pending writers.
module tb_regfile_sb;
  localparam int WIDTH = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int ZR    = 31;
  localparam int AW    = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    ra [NRD];
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             rsv_en;
  logic [AW-1:0]    rsv_a;
  logic             flush;

  regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD)) bus1 ();
  regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD)) bus0 ();

  assign bus1.ra = {ra[1], ra[0]};
  assign bus0.ra = {ra[1], ra[0]};
  assign bus1.we = we;      assign bus0.we = we;
  assign bus1.wa = wa;      assign bus0.wa = wa;
  assign bus1.wd = wd;      assign bus0.wd = wd;
  assign bus1.rsv_en = rsv_en;  assign bus0.rsv_en = rsv_en;
  assign bus1.rsv_a  = rsv_a;   assign bus0.rsv_a  = rsv_a;
  assign bus1.flush  = flush;   assign bus0.flush  = flush;

  regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(ZR), .BYPASS(1))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(ZR), .BYPASS(0))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  // reference model: register contents plus a list of registers awaiting writeback
  logic [WIDTH-1:0] x_m [NREGS];
  int busy_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic bit real_reg(int r);
    return (r != ZR) && (r < NREGS);
  endfunction

  function automatic bit is_busy(int r);
    foreach (busy_q[i]) if (busy_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(int a, bit byp);
    if (!real_reg(a)) return '0;
    if (byp && we && int'(wa) == a) return wd;
    return x_m[a];
  endfunction

  function automatic logic exp_rbusy(int a, bit byp);
    if (!real_reg(a)) return 1'b0;
    if (byp && we && int'(wa) == a) return 1'b0;
    return is_busy(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) x_m[i] = (i == ZR) ? '0 : WIDTH'(i);
    busy_q.delete();
  endtask

  task automatic model_edge();
    int keep[$];
    if (flush) begin
      busy_q.delete();
    end else begin
      if (we && real_reg(int'(wa)) && !(rsv_en && rsv_a == wa)) begin
        foreach (busy_q[i]) if (busy_q[i] != int'(wa)) keep.push_back(busy_q[i]);
        busy_q = keep;
      end
      if (rsv_en && real_reg(int'(rsv_a)) && !is_busy(int'(rsv_a)))
        busy_q.push_back(int'(rsv_a));
    end
    if (we && real_reg(int'(wa))) x_m[wa] = wd;
  endtask

  task automatic chk(string tag, logic [WIDTH-1:0] obs, logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads();
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd%0d_byp", k),    bus1.rd[k*WIDTH +: WIDTH], exp_rd(int'(ra[k]), 1'b1));
      chk($sformatf("rbusy%0d_byp", k), WIDTH'(bus1.rbusy[k]),     WIDTH'(exp_rbusy(int'(ra[k]), 1'b1)));
      chk($sformatf("rd%0d_nobyp", k),  bus0.rd[k*WIDTH +: WIDTH], exp_rd(int'(ra[k]), 1'b0));
      chk($sformatf("rbusy%0d_nobyp", k), WIDTH'(bus0.rbusy[k]),   WIDTH'(exp_rbusy(int'(ra[k]), 1'b0)));
    end
  endtask

  task automatic check_cnt();
    chk("busy_cnt_byp",   WIDTH'(bus1.busy_cnt), WIDTH'(busy_q.size()));
    chk("busy_cnt_nobyp", WIDTH'(bus0.busy_cnt), WIDTH'(busy_q.size()));
  endtask

  // driver tasks: inputs change just after negedge
  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_a = '0; flush = 1'b0;
  endtask

  task automatic tick();
    #1 check_reads();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cnt();
    check_reads();
  endtask

  task automatic reserve(int r);
    idle(); rsv_en = 1'b1; rsv_a = AW'(r); tick();
  endtask

  initial begin
    idle();
    ra[0] = 5'd5; ra[1] = 5'd31;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reads();
    check_cnt();
    chk("rst_rd5",  bus1.rd[0 +: WIDTH], 64'd5);
    chk("rst_rd31", bus1.rd[WIDTH +: WIDTH], 64'd0);
    reset_n = 1'b1;

    // write then read back; writes to the zero register vanish
    we = 1'b1; wa = 5'd3; wd = 64'hDEAD; tick();
    idle(); ra[0] = 5'd3; tick();
    chk("wr_rd3", bus1.rd[0 +: WIDTH], 64'hDEAD);
    we = 1'b1; wa = 5'd31; wd = 64'h1234; ra[1] = 5'd31; tick();
    idle(); tick();
    chk("zero_reg", bus1.rd[WIDTH +: WIDTH], 64'd0);

    // bypass visible before the edge only on the bypassing build
    idle(); we = 1'b1; wa = 5'd7; wd = 64'h55; ra[1] = 5'd7;
    #1;
    chk("bypass_pre",   bus1.rd[WIDTH +: WIDTH], 64'h55);
    chk("nobypass_pre", bus0.rd[WIDTH +: WIDTH], 64'd7);
    tick();

    // scoreboard reserve / same-cycle write+reserve / writeback clear
    idle(); ra[0] = 5'd9; ra[1] = 5'd9;
    rsv_en = 1'b1; rsv_a = 5'd9; tick();
    chk("rsv9_busy", WIDTH'(bus1.rbusy[0]), 64'd1);
    chk("rsv9_cnt",  WIDTH'(bus1.busy_cnt), 64'd1);
    idle(); we = 1'b1; wa = 5'd9; wd = 64'hAAAA; rsv_en = 1'b1; rsv_a = 5'd9; tick();
    idle(); tick();
    chk("wr_rsv9_data", bus1.rd[0 +: WIDTH], 64'hAAAA);
    chk("wr_rsv9_busy", WIDTH'(bus1.rbusy[0]), 64'd1);
    we = 1'b1; wa = 5'd9; wd = 64'hBBBB; tick();
    chk("wb9_cnt", WIDTH'(bus1.busy_cnt), 64'd0);

    // flush overrides a same-cycle reserve
    reserve(2); reserve(4); reserve(6);
    chk("three_busy", WIDTH'(bus1.busy_cnt), 64'd3);
    idle(); flush = 1'b1; rsv_en = 1'b1; rsv_a = 5'd8; ra[0] = 5'd8; tick();
    chk("flush_cnt",  WIDTH'(bus1.busy_cnt), 64'd0);
    chk("flush_rsv8", WIDTH'(bus1.rbusy[0]), 64'd0);

    // asynchronous reset in the middle of activity
    reserve(10); reserve(11); reserve(12);
    idle(); we = 1'b1; wa = 5'd1; wd = 64'hFF; ra[0] = 5'd1; ra[1] = 5'd10; tick();
    idle(); tick();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_reads();
    check_cnt();
    chk("midrst_rd1", bus1.rd[0 +: WIDTH], 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra[0]  = AW'($urandom_range(0, NREGS - 1));
      ra[1]  = AW'($urandom_range(0, NREGS - 1));
      we     = 1'($urandom_range(0, 1));
      wa     = ($urandom_range(0, 2) == 0) ? ra[$urandom_range(0, 1)]
                                           : AW'($urandom_range(0, NREGS - 1));
      wd     = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1));
      rsv_a  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
      flush  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
